// File: rtl/post_process.sv
// Output-stage post-processing: accumulate POX psum lanes over N tiles, add bias, round-shift, ReLU, saturate.
// Latency: outputs registered one edge after the final tile; no backpressure, every post_out_valid strobe is consumed.
module post_process #(
  parameter int POX        = 4,
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 16,
  parameter int TILE_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [POX*ACC_W-1:0]    pe_psum,
  input  logic                    pe_psum_valid,
  input  logic [TILE_CNT_W-1:0]   cfg_num_tiles,
  input  logic [3:0]              cfg_shift,
  input  logic                    cfg_relu_en,
  input  logic [DATA_W-1:0]       bias,
  input  logic                    clear,
  output logic [POX*DATA_W-1:0]   post_to_pooling,
  output logic                    post_out_valid,
  output logic                    busy
);

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [TILE_CNT_W-1:0]    tile_cnt_q, tile_cnt_d;
  logic                     fin_q, fin_d;
  logic signed [ACC_W-1:0]  acc_q [POX];
  logic signed [ACC_W-1:0]  acc_d [POX];
  logic [POX*DATA_W-1:0]    out_q, out_d;
  logic                     out_vld_q;

  logic [TILE_CNT_W-1:0]    last_tile;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  bias_sh;

  // Round-half-up arithmetic shift, optional ReLU, saturate to DATA_W.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [DATA_W-1:0] post_lane(
    input logic signed [ACC_W-1:0] a,
    input logic [3:0]              sh,
    input logic                    relu
  );
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    x   = {a[ACC_W-1], a};
    rnd = '0;
    if (sh != 4'd0) begin
      rnd = (ACC_W+1)'(1) << (sh - 4'd1);
    end
    r = (x + rnd) >>> sh;
    if (relu && r[ACC_W]) begin
      r = '0;
    end
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r[DATA_W-1:0];
  endfunction

  // A tile count of zero is treated as a single-tile group.
  assign last_tile = (cfg_num_tiles == '0) ? '0 : cfg_num_tiles - 1'b1;
  assign bias_ext  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign bias_sh   = bias_ext <<< cfg_shift;

  always_comb begin
    tile_cnt_d = tile_cnt_q;
    fin_d      = 1'b0;
    for (int i = 0; i < POX; i++) begin
      acc_d[i] = acc_q[i];
    end
    if (pe_psum_valid) begin
      for (int i = 0; i < POX; i++) begin
        if (tile_cnt_q == '0) begin
          acc_d[i] = $signed(pe_psum[i*ACC_W +: ACC_W]) + bias_sh;
        end else begin
          acc_d[i] = acc_q[i] + $signed(pe_psum[i*ACC_W +: ACC_W]);
        end
      end
      if (tile_cnt_q == last_tile) begin
        tile_cnt_d = '0;
        fin_d      = 1'b1;
      end else begin
        tile_cnt_d = tile_cnt_q + 1'b1;
      end
    end
  end

  // Stage 2 reads the previous acc, so a new group may start the edge after fin.
  always_comb begin
    out_d = out_q;
    if (fin_q) begin
      for (int i = 0; i < POX; i++) begin
        out_d[i*DATA_W +: DATA_W] = post_lane(acc_q[i], cfg_shift, cfg_relu_en);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tile_cnt_q <= '0;
      fin_q      <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      for (int i = 0; i < POX; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      tile_cnt_q <= tile_cnt_d;
      fin_q      <= fin_d;
      out_q      <= out_d;
      out_vld_q  <= fin_q;
      for (int i = 0; i < POX; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign post_to_pooling = out_q;
  assign post_out_valid  = out_vld_q;
  assign busy            = (tile_cnt_q != '0) || fin_q;

endmodule

// File: tb/tb_post_process.sv
// Directed bench for post_process: accumulation, rounding, saturation, streaming, reset and clear.
module tb_post_process;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  pe_psum;
  logic          pe_psum_valid;
  logic [7:0]    cfg_num_tiles;
  logic [3:0]    cfg_shift;
  logic          cfg_relu_en;
  logic [15:0]   bias;
  logic          clear;
  logic [63:0]   post_to_pooling;
  logic          post_out_valid;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  post_process dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pe_psum         (pe_psum),
    .pe_psum_valid   (pe_psum_valid),
    .cfg_num_tiles   (cfg_num_tiles),
    .cfg_shift       (cfg_shift),
    .cfg_relu_en     (cfg_relu_en),
    .bias            (bias),
    .clear           (clear),
    .post_to_pooling (post_to_pooling),
    .post_out_valid  (post_out_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_psum(input int l0, input int l1, input int l2, input int l3);
    pe_psum = {l3, l2, l1, l0};
  endtask

  function automatic logic [15:0] lane(input int i);
    return post_to_pooling[i*16 +: 16];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pe_psum_valid = 1'b0; clear = 1'b0; pe_psum = '0;
    cfg_num_tiles = 8'd1; cfg_shift = 4'd0; cfg_relu_en = 1'b0; bias = '0;
    tick(); tick();
    n_checks++;
    if (post_to_pooling !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", post_to_pooling); end
    n_checks++;
    if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", post_out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_tile();
    logic [15:0] exp [4];
    exp[0] = 16'd5; exp[1] = 16'd0; exp[2] = 16'd32767; exp[3] = 16'd7;
    cfg_num_tiles = 8'd1; cfg_shift = 4'd0; bias = 16'd0; cfg_relu_en = 1'b1;
    set_psum(5, -3, 40000, 7);
    pe_psum_valid = 1'b1;
    tick();
    pe_psum_valid = 1'b0;
    n_checks++;
    if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", post_out_valid); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    n_checks++;
    if (post_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", post_out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lane(i) !== exp[i]) begin n_fail++; $display("FAIL single_lane%0d got %h want %h", i, lane(i), exp[i]); end
    end
    tick();
    n_checks++;
    if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_strobe_len got %b want 0", post_out_valid); end
    n_checks++;
    if (lane(0) !== 16'd5) begin n_fail++; $display("FAIL single_hold got %h want 0005", lane(0)); end
  endtask

  task automatic test_multi_tile();
    int vals [3];
    vals[0] = 100; vals[1] = 200; vals[2] = 300;
    cfg_num_tiles = 8'd3; cfg_shift = 4'd2; bias = 16'd10; cfg_relu_en = 1'b1;
    pe_psum_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_psum(vals[t], vals[t], vals[t], vals[t]);
      tick();
      n_checks++;
      if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_valid_tile%0d got %b want 0", t, post_out_valid); end
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL multi_busy got %b want 1", busy); end
    pe_psum_valid = 1'b0;
    tick();
    n_checks++;
    if (post_out_valid !== 1'b1) begin n_fail++; $display("FAIL multi_valid got %b want 1", post_out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lane(i) !== 16'd160) begin n_fail++; $display("FAIL multi_lane%0d got %0d want 160", i, lane(i)); end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL multi_idle got %b want 0", busy); end
  endtask

  task automatic test_rounding();
    logic [15:0] exp [4];
    cfg_num_tiles = 8'd1; cfg_shift = 4'd2; bias = 16'd0; cfg_relu_en = 1'b0;
    exp[0] = 16'd2; exp[1] = 16'd1; exp[2] = 16'hFFFF; exp[3] = 16'hFFFE;
    set_psum(6, 5, -6, -7);
    pe_psum_valid = 1'b1;
    tick();
    pe_psum_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lane(i) !== exp[i]) begin n_fail++; $display("FAIL round_lane%0d got %h want %h", i, lane(i), exp[i]); end
    end
    tick();
    cfg_shift = 4'd0;
    exp[0] = 16'h8000; exp[1] = 16'h7FFF; exp[2] = 16'hFFFB; exp[3] = 16'h0000;
    set_psum(-40000, 40000, -5, 0);
    pe_psum_valid = 1'b1;
    tick();
    pe_psum_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lane(i) !== exp[i]) begin n_fail++; $display("FAIL sat_lane%0d got %h want %h", i, lane(i), exp[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    cfg_num_tiles = 8'd1; cfg_shift = 4'd0; bias = 16'd0; cfg_relu_en = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      pe_psum_valid = (k < 8);
      set_psum(k*1000, k*1000 - 300, k*1000 - 600, k*1000 - 900);
      tick();
      if (k >= 1) begin
        n_checks++;
        if (post_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d got %b want 1", k-1, post_out_valid); end
        for (int i = 0; i < 4; i++) begin
          e = 16'((k-1)*1000 - i*300);
          n_checks++;
          if (lane(i) !== e) begin n_fail++; $display("FAIL b2b_item%0d_lane%0d got %h want %h", k-1, i, lane(i), e); end
        end
      end
    end
    pe_psum_valid = 1'b0;
    tick();
    n_checks++;
    if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", post_out_valid); end
  endtask

  task automatic test_reset_mid_group();
    logic [15:0] exp [4];
    exp[0] = 16'd15; exp[1] = 16'd25; exp[2] = 16'hFFFB; exp[3] = 16'd105;
    cfg_num_tiles = 8'd4; cfg_shift = 4'd0; bias = 16'd5; cfg_relu_en = 1'b0;
    set_psum(1000, 1000, 1000, 1000);
    pe_psum_valid = 1'b1;
    tick(); tick();
    pe_psum_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++;
    if (post_to_pooling !== 64'd0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", post_to_pooling); end
    pe_psum_valid = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      set_psum(t, 2*t, -t, 10*t);
      tick();
      n_checks++;
      if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early%0d got %b want 0", t, post_out_valid); end
    end
    pe_psum_valid = 1'b0;
    tick();
    n_checks++;
    if (post_out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid got %b want 1", post_out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lane(i) !== exp[i]) begin n_fail++; $display("FAIL rstmid_lane%0d got %h want %h", i, lane(i), exp[i]); end
    end
    tick();
    n_checks++;
    if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_once got %b want 0", post_out_valid); end
  endtask

  task automatic test_clear();
    logic [15:0] exp [4];
    cfg_num_tiles = 8'd2; cfg_shift = 4'd0; bias = 16'd0; cfg_relu_en = 1'b1;
    set_psum(50, 50, 50, 50);
    pe_psum_valid = 1'b1;
    tick();
    set_psum(60, 60, 60, 60);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pe_psum_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", busy); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid%0d got %b want 0", c, post_out_valid); end
    end
    cfg_num_tiles = 8'd0;
    exp[0] = 16'd42; exp[1] = 16'd0; exp[2] = 16'd0; exp[3] = 16'd9;
    set_psum(42, -1, 0, 9);
    pe_psum_valid = 1'b1;
    tick();
    pe_psum_valid = 1'b0;
    n_checks++;
    if (post_out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_tiles_early got %b want 0", post_out_valid); end
    tick();
    n_checks++;
    if (post_out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_tiles_valid got %b want 1", post_out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lane(i) !== exp[i]) begin n_fail++; $display("FAIL zero_tiles_lane%0d got %h want %h", i, lane(i), exp[i]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_rounding();
    test_back_to_back();
    test_reset_mid_group();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
